serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
- Bit-serial N-bit subtractor built around a single full-subtractor bit slice (Diff = A^B^C, Bout = ~A&B | ~(A^B)&C) plus a registered borrow.
- Consumes two W-bit unsigned operands and a borrow-in, then processes one bit per clock, LSB first.
- Delivers a W-bit difference and a borrow-out with a done pulse.
- Sits directly downstream of the combinational full-subtractor slice and turns it into a multi-bit sequential datapath.

Parameters:
- W, 8, operand/result width in bits; legal range W >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted on a rising edge when busy=0
- a  input  W  minuend, sampled only on the accept edge
- b  input  W  subtrahend, sampled only on the accept edge
- bin  input  1  borrow-in, sampled only on the accept edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when diff/bout update
- diff  output  W  registered result, (a - b - bin) mod 2^W
- bout  output  1  registered borrow-out, 1 iff a < b + bin (unsigned)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE.
  - busy=0, done=0, diff=0, bout=0.
  - Operand shift registers, result shift register, borrow flop and bit counter are all cleared.
- FSM has two states: IDLE and RUN.
- IDLE:
  - If start=1 at a rising edge, then at that edge:
    - a and b load into shift registers; borrow flop <= bin.
    - counter <= 0; busy <= 1; state <= RUN.
  - No bit is processed on the accept edge.
- RUN, at each edge:
  - The slice computes (a_sh[0], b_sh[0], borrow).
  - The Diff bit shifts into the MSB of the result shift register (right shift).
  - Operand registers shift right by one.
  - borrow <= slice Bout; counter increments.
- Completion: on the edge where counter == W-1 (the W-th RUN edge):
  - diff <= the full shifted result, including the current Diff bit.
  - bout <= the current slice Bout.
  - done <= 1; busy <= 0; state <= IDLE.
- Latency: start accepted at edge k gives done=1 and a valid diff/bout in the cycle after edge k+W.
- done is high for exactly one cycle and is cleared on the next edge.
- diff and bout hold their last values until the next completion. They do not change during RUN, and they do not change on the accept edge.
- start while busy=1 is ignored. The operation in flight is unaffected and nothing is queued.
- start in the same cycle that done=1 is accepted, because busy is already 0. Back-to-back throughput is one result every W+1 cycles.
- start held high continuously restarts immediately after each done.
- Reset asserted mid-RUN:
  - Aborts the operation immediately; no done pulse is produced.
  - diff and bout return to 0.
  - After release the block is in IDLE.
- Changes on a, b or bin after the accept edge have no effect on the result.
- Width rules:
  - Counter width is clog2(W), minimum 1 bit.
  - No signed interpretation; the result wraps modulo 2^W.
- W=1:
  - The operation completes on the first RUN edge.
  - diff and bout must equal the single-bit full-subtractor truth table for (a, b, bin).

Test Plan:
- W=8, reset, then start with a=8'h05, b=8'h03, bin=0 -> busy high for 8 cycles, then done=1 for one cycle with diff=8'h02, bout=0.
- W=8, a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Then a=8'hFF, b=8'hFF, bin=1 -> diff=8'hFF, bout=1. Then a=8'h80, b=8'h7F, bin=1 -> diff=8'h00, bout=0.
- W=8, start a=8'h10, b=8'h01, then pulse start with a=8'hAA, b=8'h00 at RUN cycle 3 and toggle a/b each cycle -> exactly one done, diff=8'h0F, bout=0; the second start is ignored.
- W=8, drive rst_n=0 at RUN cycle 4 of a=8'h33, b=8'h11 -> busy, done, diff and bout go to 0 at once with no done pulse; a following start with a=8'h09, b=8'h04, bin=1 yields diff=8'h04, bout=0.
- W=8, start held high with operand pairs changed after each done -> done pulses spaced exactly 9 cycles apart, and each diff/bout matches a-b-bin for its pair.
- W=1, all 8 combinations of (a, b, bin) -> diff/bout match the full-subtractor truth table: 000->00, 001->11, 010->11, 011->01, 100->10, 101->00, 110->00, 111->11.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor: one full-subtractor slice plus a borrow flop,
// processing one bit per clock LSB first. Outputs a difference and borrow with a done pulse.
module serial_sub #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q;
    logic [W-1:0]   a_sh_q;
    logic [W-1:0]   b_sh_q;
    logic [W-1:0]   res_q;
    logic           borrow_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   diff_q;
    logic           bout_q;

    logic           slice_diff;
    logic           slice_bout;
    logic [W-1:0]   res_d;
    logic [CW-1:0]  cnt_d;

    assign slice_diff = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    assign slice_bout = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
    assign cnt_d      = cnt_q + CW'(1);

    // The new difference bit enters at the MSB so the LSB-first stream ends up in place.
    generate
        if (W == 1) begin : g_res_w1
            assign res_d = slice_diff;
        end else begin : g_res_wn
            assign res_d = {slice_diff, res_q[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= slice_bout;
                    if (cnt_q == LAST_CNT) begin
                        diff_q  <= res_d;
                        bout_q  <= slice_bout;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
endmodule

// File: tb/tb_serial_sub.sv
// Directed checks for serial_sub at W=8 and W=1 with hand-computed expectations.
module tb_serial_sub;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    logic       s1_start;
    logic [0:0] s1_a;
    logic [0:0] s1_b;
    logic       s1_bin;
    logic       s1_busy;
    logic       s1_done;
    logic [0:0] s1_diff;
    logic       s1_bout;

    int checks = 0;
    int errors = 0;

    serial_sub #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_sub #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .a(s1_a), .b(s1_b), .bin(s1_bin),
        .busy(s1_busy), .done(s1_done), .diff(s1_diff), .bout(s1_bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, then check busy every RUN cycle and the result on the W-th RUN edge.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic bi, input logic [7:0] ed, input logic eb);
        logic [7:0] prev_diff;
        prev_diff = diff;
        start = 1'b1; a = av; b = bv; bin = bi;
        tick();
        start = 1'b0; a = ~av; b = ~bv; bin = ~bi;
        chk({tag, "_busy_acc"}, busy, 1);
        chk({tag, "_diff_hold"}, diff, prev_diff);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk({tag, "_busy_run"}, {busy, done}, 2'b10);
        end
        tick();
        chk({tag, "_done"}, {busy, done}, 2'b01);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_bout"}, bout, eb);
        tick();
        chk({tag, "_done_clr"}, done, 0);
        $display("op %s a=%02h b=%02h bin=%0d diff=%02h bout=%0d", tag, av, bv, bi, diff, bout);
    endtask

    initial begin
        logic [1:0] tt [8];
        logic [2:0] idx;
        int dcount;
        int last_done;
        logic [7:0] pa [3];
        logic [7:0] pb [3];
        logic       pbi [3];
        logic [7:0] pd [3];
        logic       pbo [3];

        tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_bin = 1'b0;
        tick();
        tick();
        chk("reset_out", {busy, done, diff, bout}, 11'h000);
        chk("reset_out_w1", {s1_busy, s1_done, s1_diff, s1_bout}, 4'h0);
        rst_n = 1'b1;
        tick();

        run_op("sub05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        run_op("sub00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        run_op("subFF_FF", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op("sub80_7F", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

        // Busy-start is ignored and late operand changes have no effect.
        start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
        tick();
        start = 1'b0;
        dcount = 0;
        for (int i = 1; i <= 12; i++) begin
            start = (i == 3);
            if (i == 3) begin
                a = 8'hAA; b = 8'h00;
            end else begin
                a = ~a; b = ~b;
            end
            tick();
            if (done) dcount++;
            if (i == 4) chk("ign_diff_hold", diff, 8'h00);
            if (i == 8) begin
                chk("ign_done_time", done, 1);
                chk("ign_diff", diff, 8'h0F);
                chk("ign_bout", bout, 0);
            end
        end
        start = 1'b0;
        chk("ign_done_count", dcount, 1);
        $display("op ignore_busy_start diff=%02h bout=%0d dones=%0d", diff, bout, dcount);

        // Reset asserted in the middle of a RUN aborts with no done pulse.
        start = 1'b1; a = 8'h33; b = 8'h11; bin = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_out", {busy, done, diff, bout}, 11'h000);
        tick();
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        $display("op abort_mid_run busy=%0d diff=%02h", busy, diff);
        run_op("sub09_04", 8'h09, 8'h04, 1'b1, 8'h04, 1'b0);

        // start held high: done every 9 cycles, operands swapped on each done.
        pa  = '{8'hC8, 8'h14, 8'h7F};
        pb  = '{8'h32, 8'h1E, 8'h7F};
        pbi = '{1'b0, 1'b1, 1'b0};
        pd  = '{8'h96, 8'hF5, 8'h00};
        pbo = '{1'b0, 1'b1, 1'b0};
        start = 1'b1; a = pa[0]; b = pb[0]; bin = pbi[0];
        last_done = -1;
        dcount = 0;
        for (int cyc = 0; cyc < 40 && dcount < 3; cyc++) begin
            tick();
            if (done) begin
                chk("b2b_diff", diff, pd[dcount]);
                chk("b2b_bout", bout, pbo[dcount]);
                if (last_done >= 0) chk("b2b_spacing", cyc - last_done, 9);
                else chk("b2b_first", cyc, 8);
                $display("op b2b%0d a=%02h b=%02h bin=%0d diff=%02h bout=%0d cyc=%0d",
                         dcount, pa[dcount], pb[dcount], pbi[dcount], diff, bout, cyc);
                last_done = cyc;
                dcount++;
                if (dcount < 3) begin
                    a = pa[dcount]; b = pb[dcount]; bin = pbi[dcount];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_count", dcount, 3);
        tick();
        tick();

        // W=1: truth table of the full subtractor.
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            s1_start = 1'b1; s1_a = idx[2]; s1_b = idx[1]; s1_bin = idx[0];
            tick();
            s1_start = 1'b0;
            chk("w1_busy", {s1_busy, s1_done}, 2'b10);
            tick();
            chk("w1_done", {s1_busy, s1_done}, 2'b01);
            chk("w1_result", {s1_diff, s1_bout}, tt[i]);
            $display("op w1 abc=%03b diff=%0d bout=%0d", idx, s1_diff, s1_bout);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
